// File: rtl/learning_song_sequencer.sv
// Song ROM front end for the learning-mode note checker.
// Presents one entry at a time and prefetches the next one.
module learning_song_sequencer #(
   parameter int SONG_SEL_W = 2,
   parameter int IDX_W      = 5,
   parameter int MAX_NOTES  = 26,
   parameter int DUR_W      = 26
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        abort,
   input  logic [SONG_SEL_W-1:0]       song_sel,
   output logic                        rom_en,
   output logic [SONG_SEL_W+IDX_W-1:0] rom_addr,
   input  logic [3:0]                  rom_note,
   input  logic [DUR_W-1:0]            rom_dur,
   input  logic [IDX_W-1:0]            req_location,
   output logic [3:0]                  note_value,
   output logic [DUR_W-1:0]            duration_value,
   output logic                        isvalid,
   output logic                        busy,
   output logic                        done,
   output logic [IDX_W-1:0]            notes_played
);

   typedef enum logic [3:0] {
      IDLE, F0, W0, F1, W1, PRESENT, PF, PW, DONE
   } state_t;

   localparam logic [IDX_W-1:0] LAST = IDX_W'(MAX_NOTES - 1);
   localparam logic [IDX_W-1:0] MAXN = IDX_W'(MAX_NOTES);

   state_t state_q, state_d;

   logic [SONG_SEL_W-1:0] song_q;
   logic [IDX_W-1:0]      cur_idx;
   logic [IDX_W-1:0]      next_idx;
   logic [IDX_W-1:0]      fetch_idx;
   logic [3:0]            sh_note;
   logic [DUR_W-1:0]      sh_dur;
   logic                  sh_term;

   logic load, cap_cur, cap_sh, go_valid;
   logic adv, restart, finish;

   assign next_idx = (cur_idx == LAST) ? '0 : cur_idx + 1'b1;
   assign rom_addr = rom_en ? {song_q, fetch_idx} : '0;
   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // next state, ROM strobe and datapath controls
   always_comb begin
      state_d   = state_q;
      rom_en    = 1'b0;
      fetch_idx = '0;
      load      = 1'b0;
      cap_cur   = 1'b0;
      cap_sh    = 1'b0;
      go_valid  = 1'b0;
      adv       = 1'b0;
      restart   = 1'b0;
      finish    = 1'b0;
      if (abort) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  load    = 1'b1;
                  state_d = F0;
               end
            end
            F0: begin
               rom_en  = 1'b1;
               state_d = W0;
            end
            W0: begin
               cap_cur = 1'b1;
               if (rom_dur == '0) begin
                  finish  = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = F1;
               end
            end
            F1: begin
               rom_en    = 1'b1;
               fetch_idx = IDX_W'(1);
               state_d   = W1;
            end
            W1: begin
               cap_sh   = 1'b1;
               go_valid = 1'b1;
               state_d  = PRESENT;
            end
            PRESENT: begin
               if (req_location == next_idx) begin
                  if (next_idx == '0 || sh_term) begin
                     finish  = 1'b1;
                     state_d = DONE;
                  end else begin
                     adv     = 1'b1;
                     state_d = PF;
                  end
               end else if (req_location == '0 && cur_idx != '0 &&
                            cur_idx != LAST) begin
                  restart = 1'b1;
                  state_d = F0;
               end
            end
            PF: begin
               rom_en    = 1'b1;
               fetch_idx = next_idx;
               state_d   = PW;
            end
            PW: begin
               cap_sh  = 1'b1;
               state_d = PRESENT;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // current entry, shadow entry, index and progress registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         song_q         <= '0;
         cur_idx        <= '0;
         sh_note        <= '0;
         sh_dur         <= '0;
         sh_term        <= 1'b0;
         note_value     <= '0;
         duration_value <= '0;
         isvalid        <= 1'b0;
         notes_played   <= '0;
      end else if (abort) begin
         isvalid        <= 1'b0;
         note_value     <= '0;
         duration_value <= '0;
      end else begin
         if (load) begin
            song_q       <= song_sel;
            cur_idx      <= '0;
            notes_played <= '0;
         end
         if (cap_cur) begin
            note_value     <= rom_note;
            duration_value <= rom_dur;
         end
         if (cap_sh) begin
            sh_note <= rom_note;
            sh_dur  <= rom_dur;
            sh_term <= (rom_dur == '0);
         end
         if (go_valid) isvalid <= 1'b1;
         if (adv) begin
            note_value     <= sh_note;
            duration_value <= sh_dur;
            cur_idx        <= next_idx;
            if (notes_played != MAXN)
               notes_played <= notes_played + 1'b1;
         end
         if (restart) begin
            isvalid <= 1'b0;
            cur_idx <= '0;
         end
         if (finish) begin
            isvalid        <= 1'b0;
            note_value     <= '0;
            duration_value <= '0;
         end
      end
   end

endmodule

// File: tb/tb_learning_song_sequencer.sv
// Bench for learning_song_sequencer: ROM stub plus a
// song-level model of what the checker should see.
module tb_learning_song_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        abort;
   logic [1:0]  song_sel;
   logic        rom_en;
   logic [6:0]  rom_addr;
   logic [3:0]  rom_note;
   logic [25:0] rom_dur;
   logic [4:0]  req_location;
   logic [3:0]  note_value;
   logic [25:0] duration_value;
   logic        isvalid;
   logic        busy;
   logic        done;
   logic [4:0]  notes_played;

   int total = 0;
   int bad   = 0;
   int done_cnt = 0;

   logic [3:0]  mem_note [128];
   logic [25:0] mem_dur  [128];
   logic [6:0]  flog [$];

   learning_song_sequencer dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .abort          (abort),
      .song_sel       (song_sel),
      .rom_en         (rom_en),
      .rom_addr       (rom_addr),
      .rom_note       (rom_note),
      .rom_dur        (rom_dur),
      .req_location   (req_location),
      .note_value     (note_value),
      .duration_value (duration_value),
      .isvalid        (isvalid),
      .busy           (busy),
      .done           (done),
      .notes_played   (notes_played)
   );

   always #5 clk = ~clk;

   // registered song ROM and fetch log
   always @(posedge clk) begin
      if (rom_en) begin
         rom_note <= mem_note[rom_addr];
         rom_dur  <= mem_dur[rom_addr];
         flog.push_back(rom_addr);
      end
      if (done) done_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic load_song(input int s, input int len);
      for (int i = 0; i < 26; i++) begin
         mem_note[s*32+i] = 4'($urandom_range(0, 15));
         mem_dur[s*32+i]  = 26'($urandom_range(1, 1000));
         if (i == len) mem_dur[s*32+i] = '0;
      end
   endtask

   task automatic start_song(input int s);
      song_sel = 2'(s);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // counts edges from the triggering edge (=1) until isvalid
   task automatic wait_valid(output int n);
      n = 1;
      while (!isvalid && n < 15) begin
         tick();
         n++;
      end
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_valid"}, isvalid, 0);
      chk({tag, "_note"}, note_value, 0);
      chk({tag, "_dur"}, duration_value, 0);
      chk({tag, "_romen"}, rom_en, 0);
      chk({tag, "_done"}, done, 0);
   endtask

   // play a song with terminator at index len (26 = full, wraps)
   task automatic play(input int s, input int len);
      int n, fb, nexp, seen;
      flog.delete();
      start_song(s);
      if (len == 0) begin
         seen = isvalid;
         tick();
         seen |= isvalid;
         tick();
         chk("empty_done", done, 1);
         chk("empty_valid", seen | isvalid, 0);
         tick();
         chk("empty_idle", busy, 0);
      end else begin
         wait_valid(n);
         chk("lat_valid", n, 5);
         chk("first_note", note_value, mem_note[s*32]);
         chk("first_dur", duration_value, mem_dur[s*32]);
         for (int i = 1; i <= len; i++) begin
            req_location = 5'(i % 26);
            tick();
            if (i == len) begin
               chk("end_done", done, 1);
               chk("end_valid", isvalid, 0);
               chk("end_note", note_value, 0);
               chk("end_np", notes_played, len - 1);
               tick();
               chk("end_pulse", done, 0);
               chk("end_idle", busy, 0);
               chk("end_np_hold", notes_played, len - 1);
            end else begin
               chk("adv_note", note_value, mem_note[s*32+i]);
               chk("adv_dur", duration_value, mem_dur[s*32+i]);
               chk("adv_np", notes_played, i);
               chk("adv_valid", isvalid, 1);
               repeat (3) tick();
            end
         end
      end
      nexp = (len == 0) ? 1 : len + 1;
      chk("fetch_n", flog.size(), nexp);
      fb = 0;
      for (int j = 0; j < flog.size() && j < nexp; j++)
         if (flog[j] !== 7'(s*32 + (j % 26))) fb++;
      chk("fetch_addr", fb, 0);
      req_location = '0;
      tick();
   endtask

   initial begin
      int n, dc, sb;
      rst = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      song_sel = '0;
      req_location = '0;
      repeat (2) tick();
      check_idle("rst");
      chk("rst_addr", rom_addr, 0);
      chk("rst_np", notes_played, 0);
      rst = 1'b0;
      tick();

      load_song(1, 2);
      mem_note[32] = 4'd5;
      mem_dur[32]  = 26'd100;
      mem_note[33] = 4'd3;
      mem_dur[33]  = 26'd200;
      play(1, 2);

      load_song(2, 26);
      play(2, 26);

      load_song(3, 0);
      play(3, 0);

      for (int r = 0; r < 6; r++) begin
         int s, l;
         s = $urandom_range(0, 3);
         l = $urandom_range(0, 26);
         load_song(s, l);
         play(s, l);
      end

      // restart from the checker and ignored start
      load_song(0, 26);
      start_song(0);
      wait_valid(n);
      for (int i = 1; i <= 4; i++) begin
         req_location = 5'(i);
         repeat (4) tick();
      end
      chk("mid_note", note_value, mem_note[4]);
      flog.delete();
      song_sel = 2'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("ign_busy", busy, 1);
      chk("ign_valid", isvalid, 1);
      chk("ign_note", note_value, mem_note[4]);
      req_location = '0;
      tick();
      chk("rs_valid", isvalid, 0);
      wait_valid(n);
      chk("rs_lat", n, 5);
      chk("rs_note", note_value, mem_note[0]);
      chk("rs_dur", duration_value, mem_dur[0]);
      chk("rs_addr0", (flog.size() > 0) ? flog[0] : 7'h7f, 0);
      sb = 0;
      foreach (flog[j]) if (flog[j][6:5] != 2'd0) sb++;
      chk("rs_song", sb, 0);

      // abort while in PW
      dc = done_cnt;
      req_location = 5'd1;
      tick();
      chk("ab_note", note_value, mem_note[1]);
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_idle("abort");
      repeat (3) tick();
      chk("ab_nodone", done_cnt, dc);
      req_location = '0;

      // start and abort together
      song_sel = 2'd2;
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk("sa_busy", busy, 0);

      // asynchronous reset during W0
      start_song(2);
      tick();
      rst = 1'b1;
      #1;
      check_idle("arst");
      tick();
      rst = 1'b0;
      tick();
      check_idle("arst2");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got 1 want 0");
      $fatal(1, "timeout");
   end

endmodule
